// File: rtl/shift_reg_sequencer_pkg.sv
// Shared definitions for the shift-register sequencer: command opcodes,
// FSM states and the register data width.
package shift_reg_sequencer_pkg;

    localparam int unsigned SR_DATA_W = 8;

    // Opcodes share the encoding of the register's c1/c0 mode lines.
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } seq_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'b00,
        SEQ_LOAD  = 2'b01,
        SEQ_SHIFT = 2'b10,
        SEQ_DONE  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/seq_step_counter.sv
// Loadable down-counter that sequences shift cycles; last flags a count of 1.
module seq_step_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    // last is kept registered alongside count so it tracks the value being held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            last  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            last  <= (load_val == CNT_W'(1));
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
            last  <= (count == CNT_W'(2));
        end
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for the 8-bit universal shift register.
// Optional right-shift flag capture is built when SEQ_FLAG_CAPTURE_EN is defined.
module shift_reg_sequencer
    import shift_reg_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic                 seq_clk,
    input  logic                 seq_rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CNT_W-1:0]     cmd_count,
    input  logic [SR_DATA_W-1:0] cmd_data,
    output logic                 sr_en,
    output logic                 sr_c1,
    output logic                 sr_c0,
    output logic [SR_DATA_W-1:0] sr_data,
    input  logic                 sr_flag,
    output logic                 busy,
    output logic                 done,
    output logic [SR_DATA_W-1:0] cap_data
);

    seq_state_e           state, state_nxt;
    seq_op_e              op_q, op_nxt;
    logic                 accept_c;
    logic                 cnt_load, cnt_dec, cnt_last;
    logic [CNT_W-1:0]     cnt_val;
    logic                 en_nxt, ready_nxt, busy_nxt, done_nxt;
    logic [1:0]           mode_nxt;
    logic [SR_DATA_W-1:0] data_nxt;

    assign accept_c = cmd_valid && cmd_ready;

    seq_step_counter #(.CNT_W(CNT_W)) u_step_counter (
        .clk      (seq_clk),
        .rst_n    (seq_rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cmd_count),
        .count    (cnt_val),
        .last     (cnt_last)
    );

    // Next state plus next values of the registered outputs
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        en_nxt    = 1'b0;
        mode_nxt  = 2'b00;
        data_nxt  = '0;

        case (state)
            SEQ_IDLE: begin
                if (accept_c) begin
                    op_nxt   = seq_op_e'(cmd_op);
                    cnt_load = 1'b1;
                    case (seq_op_e'(cmd_op))
                        OP_LOAD:        state_nxt = SEQ_LOAD;
                        OP_SHR, OP_SHL: state_nxt = (cmd_count != '0) ? SEQ_SHIFT : SEQ_DONE;
                        default:        state_nxt = SEQ_DONE;
                    endcase
                end
            end
            SEQ_LOAD:  state_nxt = SEQ_DONE;
            SEQ_SHIFT: begin
                cnt_dec = 1'b1;
                if (cnt_last) state_nxt = SEQ_DONE;
            end
            default:   state_nxt = SEQ_IDLE;
        endcase

        // LOAD is only entered straight from acceptance, so cmd_data is the latched value
        case (state_nxt)
            SEQ_LOAD: begin
                en_nxt   = 1'b1;
                mode_nxt = 2'(OP_LOAD);
                data_nxt = cmd_data;
            end
            SEQ_SHIFT: begin
                en_nxt   = 1'b1;
                mode_nxt = 2'(op_nxt);
            end
            default: ;
        endcase

        ready_nxt = (state_nxt == SEQ_IDLE);
        busy_nxt  = (state_nxt != SEQ_IDLE);
        done_nxt  = (state_nxt == SEQ_DONE);
    end

    always_ff @(posedge seq_clk or negedge seq_rst_n) begin
        if (!seq_rst_n) begin
            state     <= SEQ_IDLE;
            op_q      <= OP_NOP;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sr_en     <= 1'b0;
            sr_c1     <= 1'b0;
            sr_c0     <= 1'b0;
            sr_data   <= '0;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            cmd_ready <= ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            sr_en     <= en_nxt;
            sr_c1     <= mode_nxt[1];
            sr_c0     <= mode_nxt[0];
            sr_data   <= data_nxt;
        end
    end

`ifdef SEQ_FLAG_CAPTURE_EN
    logic shr_fire_q;

    // Flag lags each right shift by one edge, so capture runs off a delayed fire
    always_ff @(posedge seq_clk or negedge seq_rst_n) begin
        if (!seq_rst_n) begin
            shr_fire_q <= 1'b0;
            cap_data   <= '0;
        end else begin
            shr_fire_q <= sr_en && ({sr_c1, sr_c0} == 2'(OP_SHR));
            if (accept_c && (seq_op_e'(cmd_op) == OP_SHR)) begin
                cap_data <= '0;
            end else if (shr_fire_q) begin
                cap_data <= {sr_flag, cap_data[SR_DATA_W-1:1]};
            end
        end
    end
`else
    logic unused_flag;

    assign unused_flag = sr_flag;
    assign cap_data    = '0;
`endif

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Randomized scoreboard bench for shift_reg_sequencer with a behavioural
// shift-register model driving sr_flag.
`timescale 1ns/1ps
module tb_shift_reg_sequencer;
    import shift_reg_sequencer_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_count = '0;
    logic [7:0]       cmd_data = 8'h00;
    logic             sr_en, sr_c1, sr_c0;
    logic [7:0]       sr_data;
    logic             sr_flag;
    logic             busy, done;
    logic [7:0]       cap_data;

    always #5 clk = ~clk;

    shift_reg_sequencer #(.CNT_W(CNT_W)) dut (
        .seq_clk   (clk),
        .seq_rst_n (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .sr_en     (sr_en),
        .sr_c1     (sr_c1),
        .sr_c0     (sr_c0),
        .sr_data   (sr_data),
        .sr_flag   (sr_flag),
        .busy      (busy),
        .done      (done),
        .cap_data  (cap_data)
    );

    // Universal shift register being controlled; shifts fill with zero
    logic [7:0] reg_q  = 8'h00;
    logic       flag_q = 1'b0;
    always @(posedge clk) begin
        if (sr_en) begin
            case ({sr_c1, sr_c0})
                2'b01: begin flag_q <= reg_q[0]; reg_q <= {1'b0, reg_q[7:1]}; end
                2'b10: begin flag_q <= reg_q[7]; reg_q <= {reg_q[6:0], 1'b0}; end
                2'b11: reg_q <= sr_data;
                default: ;
            endcase
        end
    end
    assign sr_flag = flag_q;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        int         en_cycles;
        int         latency;
        logic [7:0] reg_v;
        logic [7:0] cap_v;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         en_cnt = 0;
    int         last_done_cyc = -100;
    bit         cap_pending = 1'b0;
    logic [7:0] pend_cap = 8'h00;
    bit         armed = 1'b0;
    logic [7:0] ref_v = 8'h00;
    logic [7:0] ref_cap = 8'h00;
    exp_t       mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt      = 0;
            cap_pending = 1'b0;
            chk("reset_outputs",
                {20'd0, cmd_ready, busy, done, sr_en, sr_c1, sr_c0, |sr_data, |cap_data}, 32'd0);
        end else begin
            if (cap_pending) begin
                chk("cap_data", 32'(cap_data), 32'(pend_cap));
                cap_pending = 1'b0;
            end
            if (sr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sr_en", 32'(sr_en), 32'd0);
                end else begin
                    en_cnt++;
                    chk("sr_mode", 32'({sr_c1, sr_c0}), 32'(exp_q[0].op));
                    if (exp_q[0].op == 2'(OP_LOAD)) chk("sr_data", 32'(sr_data), 32'(exp_q[0].data));
                end
            end else begin
                chk("idle_lines", 32'({sr_c1, sr_c0, sr_data}), 32'd0);
            end
            if (armed) chk("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("en_cycles", 32'(en_cnt), 32'(mon_e.en_cycles));
                    chk("done_latency", 32'(cyc - mon_e.acc), 32'(mon_e.latency));
                    chk("register_value", 32'(reg_q), 32'(mon_e.reg_v));
                    pend_cap      = mon_e.cap_v;
                    cap_pending   = 1'b1;
                    last_done_cyc = cyc;
                end
                en_cnt = 0;
            end else if (exp_q.size() > 0 && (cyc - exp_q[0].acc) > 40) begin
                chk("done_timeout", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].latency));
                void'(exp_q.pop_front());
                en_cnt = 0;
            end
        end
    end

    // Present one command, wait for acceptance and push its expected outcome
    task automatic issue(input logic [1:0] op, input int n, input logic [7:0] d,
                         input bit hold, input bit b2b);
        exp_t e;
        int   w;
        int   wide;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CNT_W'(n);
        cmd_data  = d;
        w = 0;
        while (!cmd_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        if (b2b) chk("b2b_accept_cycle", 32'(cyc), 32'(last_done_cyc + 1));
        e.op  = op;
        e.data = d;
        e.acc = cyc;
        case (op)
            2'(OP_LOAD): begin ref_v = d; e.en_cycles = 1; e.latency = 2; end
            2'(OP_SHR): begin
`ifdef SEQ_FLAG_CAPTURE_EN
                wide    = int'(ref_v) * 256;
                ref_cap = 8'(wide >> n);
`endif
                wide  = int'(ref_v);
                ref_v = 8'(wide >> n);
                e.en_cycles = n;
                e.latency   = (n == 0) ? 1 : n + 1;
            end
            2'(OP_SHL): begin
                wide  = int'(ref_v);
                ref_v = 8'(wide << n);
                e.en_cycles = n;
                e.latency   = (n == 0) ? 1 : n + 1;
            end
            default: begin e.en_cycles = 0; e.latency = 1; end
        endcase
        e.reg_v = ref_v;
        e.cap_v = ref_cap;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  op;
        bit  hold, prev_hold;
        exp_t e;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);
        chk("busy_after_reset", 32'(busy), 32'd0);
        armed = 1'b1;

        // Directed sequences
        issue(2'(OP_LOAD), 0, 8'hA5, 1'b0, 1'b0);
        issue(2'(OP_SHR), 8, 8'h00, 1'b0, 1'b0);
        issue(2'(OP_LOAD), 5, 8'hA5, 1'b0, 1'b0);
        issue(2'(OP_SHR), 3, 8'h3C, 1'b0, 1'b0);
        issue(2'(OP_SHL), 2, 8'hFF, 1'b0, 1'b0);
        issue(2'(OP_SHL), 0, 8'h11, 1'b1, 1'b0);
        issue(2'(OP_NOP), 7, 8'h22, 1'b0, 1'b1);
        drain();

        // Reset in the 4th shift cycle of SHR 10 abandons the command
        issue(2'(OP_SHR), 10, 8'h00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("abort_sr_en_before", 32'(sr_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs",
            {28'd0, sr_en, busy, done, cmd_ready}, 32'd0);
        armed = 1'b0;
        exp_q.delete();
        ref_cap = 8'h00;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 32'(cmd_ready), 32'd1);
        chk("busy_after_abort", 32'(busy), 32'd0);
        armed = 1'b1;
        issue(2'(OP_LOAD), 0, 8'h5A, 1'b0, 1'b0);

        // Randomized commands, sometimes with cmd_valid held between them
        prev_hold = 1'b0;
        for (int i = 0; i < 150; i++) begin
            op   = int'($urandom_range(0, 3));
            n    = int'($urandom_range(0, 15));
            hold = (i == 149) ? 1'b0 : 1'($urandom_range(0, 1));
            issue(2'(op), n, 8'($urandom), hold, prev_hold);
            prev_hold = hold;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
